// File: rtl/seq_det_sched.sv
// Shared serial pattern detector: a round-robin scheduler picks one bit-serial
// channel per cycle; per-channel history/fill and saturating match counters live in lanes.

module seq_det_lane #(
  parameter int              PLEN    = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b10101,
  parameter int              CNTW    = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            acc,
  input  logic            din,
  input  logic            flush,
  input  logic            cnt_clr,
  output logic            hit,
  output logic [CNTW-1:0] cnt
);
  localparam int FW = $clog2(PLEN);
  localparam logic [FW-1:0] FULL = FW'(PLEN-1);

  logic [PLEN-2:0] hist;
  logic [FW-1:0]   fill;
  logic [PLEN-1:0] w;

  assign w = {hist, din};
  // A flushed channel still consumes the granted bit but never reports a hit.
  assign hit = acc & ~flush & (fill == FULL) & (w == PATTERN);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist <= '0;
      fill <= '0;
      cnt  <= '0;
    end else begin
      if (flush) begin
        hist <= '0;
        fill <= '0;
      end else if (acc) begin
        hist <= w[PLEN-2:0];
        if (fill != FULL) fill <= fill + 1'b1;
      end
      if (cnt_clr)              cnt <= '0;
      else if (hit && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

module seq_det_sched #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b10101,
  parameter int              CNTW    = 8,
  localparam int             CW      = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            en,
  input  logic [NCH-1:0]  req_valid,
  input  logic [NCH-1:0]  req_bit,
  output logic [NCH-1:0]  req_ready,
  input  logic [NCH-1:0]  ch_flush,
  input  logic            cnt_clr,
  output logic            match_valid,
  output logic [CW-1:0]   match_ch,
  input  logic [CW-1:0]   rd_sel,
  output logic [CNTW-1:0] rd_cnt
);
  logic [CW-1:0]             rr_ptr;
  logic [CW-1:0]             gidx;
  logic                      gany;
  logic [NCH-1:0]            gnt;
  logic [NCH-1:0]            hit;
  logic [NCH-1:0][CNTW-1:0]  cnts;

  // Search starts one past the last winner; req_bit never enters this path.
  always_comb begin
    int idx;
    idx  = 0;
    gany = 1'b0;
    gidx = '0;
    gnt  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (en && !gany && req_valid[idx]) begin
        gany = 1'b1;
        gidx = CW'(idx);
      end
    end
    if (gany) gnt[gidx] = 1'b1;
  end

  assign req_ready = gnt;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    seq_det_lane #(.PLEN(PLEN), .PATTERN(PATTERN), .CNTW(CNTW)) u_lane (
      .clk     (clk),
      .clr_n   (clr_n),
      .acc     (gnt[i] & req_valid[i]),
      .din     (req_bit[i]),
      .flush   (ch_flush[i]),
      .cnt_clr (cnt_clr),
      .hit     (hit[i]),
      .cnt     (cnts[i])
    );
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rr_ptr      <= CW'(NCH-1);
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      if (gany) rr_ptr <= gidx;
      match_valid <= |hit;
      if (|hit) match_ch <= gidx;
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_sel == CW'(i)) rd_cnt = cnts[i];
  end
endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized + directed bench: a queue-based reference model predicts grants,
// matches and counts; a monitor pops expected matches as the DUT reports them.

module tb_seq_det_sched;
  localparam int NCH = 4, PLEN = 5, CNTW = 2;
  localparam logic [PLEN-1:0] PAT = 5'b10101;
  localparam int CW = $clog2(NCH);

  logic clk = 0, clr_n = 0, en = 0, cnt_clr = 0;
  logic [NCH-1:0] req_valid = '0, req_bit = '0, ch_flush = '0, req_ready;
  logic match_valid;
  logic [CW-1:0] match_ch, rd_sel = '0;
  logic [CNTW-1:0] rd_cnt;

  seq_det_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN(PAT), .CNTW(CNTW)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(req_ready), .ch_flush(ch_flush), .cnt_clr(cnt_clr),
    .match_valid(match_valid), .match_ch(match_ch), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  typedef struct { int ch; int cyc; } exp_t;
  exp_t expq[$];
  bit   hq[NCH][$];   // bits received since last flush/reset, oldest first
  int   mcnt[NCH];
  int   rr;
  logic [PLEN-1:0] pat = PAT;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (match_valid) begin
      if (expq.size() == 0 || expq[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL spurious_match: got match_valid=1 ch %0d expected none (cyc %0d)", match_ch, cyc);
      end else begin
        chk("match_ch", match_ch, expq[0].ch);
        void'(expq.pop_front());
      end
    end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
      checks++; errors++;
      $display("FAIL missed_match: got match_valid=0 expected match on ch %0d (cyc %0d)", expq[0].ch, cyc);
      void'(expq.pop_front());
    end
  end

  task automatic step(input logic e, input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] f, input logic cc, input int rs);
    int g;
    logic [NCH-1:0] expr;
    bit hit;
    @(negedge clk);
    en = e; req_valid = v; req_bit = b; ch_flush = f; cnt_clr = cc;
    rd_sel = (rs < 0) ? CW'($urandom_range(NCH-1, 0)) : CW'(rs);
    #1;
    chk("rd_cnt", rd_cnt, mcnt[rd_sel]);
    g = -1;
    if (e) for (int k = 1; k <= NCH; k++) if (g < 0 && v[(rr+k)%NCH]) g = (rr+k)%NCH;
    expr = '0;
    if (g >= 0) expr[g] = 1'b1;
    chk("req_ready", req_ready, expr);
    hit = 0;
    if (g >= 0) begin
      rr = g;
      if (!f[g]) begin
        hq[g].push_back(b[g]);
        if (hq[g].size() > PLEN) void'(hq[g].pop_front());
        if (hq[g].size() == PLEN) begin
          hit = 1;
          for (int j = 0; j < PLEN; j++) if (hq[g][j] != pat[PLEN-1-j]) hit = 0;
        end
      end
    end
    for (int c = 0; c < NCH; c++) if (f[c]) hq[c].delete();
    if (hit) expq.push_back('{g, cyc + 1});
    if (cc) for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    else if (hit && mcnt[g] < 2**CNTW - 1) mcnt[g]++;
  endtask

  task automatic send_bits(input int ch, input logic [15:0] v, input int n);
    for (int i = n-1; i >= 0; i--)
      step(1'b1, NCH'(1) << ch, {NCH{v[i]}}, '0, 1'b0, ch);
  endtask

  task automatic flush_ch(input int ch);
    step(1'b1, '0, '0, NCH'(1) << ch, 1'b0, ch);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; req_valid = '0; ch_flush = '0; cnt_clr = 0; rd_sel = '0;
    #2 clr_n = 0;
    #1;
    chk("rst_match_valid", match_valid, 0);
    chk("rst_match_ch", match_ch, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    rr = NCH-1;
    for (int c = 0; c < NCH; c++) begin hq[c].delete(); mcnt[c] = 0; end
    expq.delete();
    @(negedge clk);
    clr_n = 1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] fm;
    rr = NCH-1;
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    repeat (2) @(negedge clk);
    chk("init_match_valid", match_valid, 0);
    chk("init_match_ch", match_ch, 0);
    chk("init_rd_cnt", rd_cnt, 0);
    clr_n = 1;

    // single channel, then an overlapping second match
    send_bits(0, 16'b10101, 5);
    send_bits(0, 16'b01, 2);
    step(1'b0, '0, '0, '0, 1'b0, 0);

    // fairness: all valid, then only ch2/ch3
    repeat (8) step(1'b1, '1, NCH'($urandom), '0, 1'b0, -1);
    repeat (4) step(1'b1, 4'b1100, NCH'($urandom), '0, 1'b0, -1);

    // interleaved isolation
    step(1'b1, '0, '0, '1, 1'b0, -1);
    for (int j = PLEN-1; j >= 0; j--) begin
      send_bits(1, {15'b0, pat[j]}, 1);
      send_bits(2, {15'b0, pat[j]}, 1);
    end
    step(1'b1, '0, '0, '1, 1'b0, -1);
    send_bits(1, 16'b101, 3);
    send_bits(2, 16'b01, 2);

    // flush with coincident bit, fresh pattern, cnt_clr coincident with hit
    flush_ch(0);
    send_bits(0, 16'b1010, 4);
    step(1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
    send_bits(0, 16'b10101, 5);
    send_bits(0, 16'b0, 1);
    step(1'b1, 4'b0001, 4'b0001, '0, 1'b1, 0);
    step(1'b0, '0, '0, '0, 1'b0, 0);

    // counter saturation on ch3
    flush_ch(3);
    send_bits(3, 16'b1010101010101, 13);
    send_bits(3, 16'b01, 2);
    step(1'b0, '0, '0, '0, 1'b0, 3);

    // reset mid-stream with a match in flight
    send_bits(0, 16'b1010, 4);
    flush_ch(1);
    send_bits(1, 16'b10101, 5);
    do_reset();
    send_bits(0, 16'b1, 1);
    step(1'b1, 4'b1010, NCH'($urandom), '0, 1'b0, -1);

    // randomized traffic
    repeat (3000) begin
      if ($urandom_range(999, 0) == 0) do_reset();
      else begin
        fm = '0;
        for (int c = 0; c < NCH; c++) fm[c] = ($urandom_range(31, 0) == 0);
        step($urandom_range(9, 0) != 0, NCH'($urandom), NCH'($urandom), fm,
             $urandom_range(63, 0) == 0, -1);
      end
    end
    repeat (2) step(1'b0, '0, '0, '0, 1'b0, -1);
    chk("pending_matches", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Time-multiplexed serial pattern-detection engine shared among NCH independent bit-serial channels.
- A round-robin scheduler grants at most one channel per cycle and feeds its bit into a single shared match datapath.
- Each channel's detection context (bit history plus fill count) is saved and restored per grant.
- Per-channel match events are reported, and match counts are accumulated for status readback.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- PLEN, 5, pattern length in bits (2..16).
- PATTERN, 5'b10101, target pattern; MSB is the earliest received bit.
- CNTW, 8, width of each per-channel saturating match counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; 0 = no grants, all state holds.
- req_valid  in  NCH  per-channel bit-valid.
- req_bit  in  NCH  per-channel serial data bit.
- req_ready  out  NCH  per-channel grant (combinational, one-hot or zero).
- ch_flush  in  NCH  per-channel synchronous context clear.
- cnt_clr  in  1  synchronous clear of all match counters.
- match_valid  out  1  registered one-cycle match pulse.
- match_ch  out  clog2(NCH)  channel index of the reported match.
- rd_sel  in  clog2(NCH)  counter readback select.
- rd_cnt  out  CNTW  match counter of channel rd_sel (combinational mux).

Behaviour:
- Reset (clr_n=0, asynchronous): all hist, fill and counters = 0; match_valid=0; match_ch=0; rr_ptr=NCH-1, so channel 0 has first priority.
- Arbitration, combinational:
  - When en=1, grant the first channel with req_valid=1, searching rr_ptr+1, rr_ptr+2, … modulo NCH.
  - req_ready is 1 only for the granted channel. It is all-zero when en=0 or no valid is present.
  - req_ready must not depend on req_bit.
- Accept = req_valid[i] & req_ready[i]. On accept, rr_ptr <= i. Without an accept, rr_ptr holds.
- Context per channel:
  - hist[i]: PLEN-1 bits.
  - fill[i]: saturating at PLEN-1.
- On accept with bit b:
  - w = {hist[i], b}.
  - hit = (fill[i] == PLEN-1) && (w == PATTERN).
  - hist[i] <= w[PLEN-2:0].
  - fill[i] <= min(fill[i]+1, PLEN-1).
  - Overlapping matches are permitted; history is not cleared on a hit.
- Match report (latency 1 cycle after accept edge):
  - match_valid <= hit.
  - match_ch <= i when hit, otherwise match_ch holds.
  - At most one match per cycle.
- Counters: on hit, cnt[i] <= cnt[i]+1, saturating at 2^CNTW-1 (no wrap).
- cnt_clr:
  - Sets all cnt to 0 next edge; it wins over a simultaneous hit increment.
  - Does not affect hist, fill or match_valid.
- ch_flush[i]:
  - Sets hist[i] and fill[i] to 0 next edge.
  - If the same channel is accepted in that cycle, flush wins: the bit is consumed (req_ready stays asserted) but discarded, and hit is forced to 0.
  - Flushing a channel does not alter rr_ptr rules.
- en=0: no accepts, no hits; match_valid returns to 0 next edge; contexts, counters and rr_ptr hold.
- Channels are fully independent: no history crosses channels regardless of interleaving.
- Reset asserted mid-stream discards all contexts; the first match after release needs PLEN fresh bits on that channel.

Test Plan:
- Single channel, PATTERN=10101: ch0 sends 1,0,1,0,1 back-to-back → match_valid=1, match_ch=0 exactly one cycle after the 5th accept, and rd_cnt(sel 0)=1. Further bits 0,1 → second overlapping match, cnt=2.
- Fairness: all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3, one req_ready high per cycle. With only ch2 and ch3 valid → strict alternation 2,3,2,3.
- Interleaved isolation: ch1 and ch2 each stream 10101 while alternating grants → one match per channel (match_ch=1 then 2), and no match from a cross-channel mix. A stream 1,0,1 on ch1 followed by 0,1 on ch2 → no match.
- Flush and cnt_clr: ch0 sends 1,0,1,0, then ch_flush[0] together with bit 1 → no match, fill reset, and a fresh 10101 is needed. A cnt_clr pulse coincident with a hit → cnt=0 afterwards.
- Saturation, CNTW=2: six matches on ch3 → rd_cnt stays 3 after the 3rd match, with no wrap to 0.
- Reset mid-operation: clr_n pulled low asynchronously after ch0 has 1,0,1,0 → outputs 0 immediately, rr_ptr=NCH-1. After release a single bit 1 gives no match; the first grant goes to the lowest valid channel.
